fetch_sequencer: RTL and testbench

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/fetch_sequencer.sv | 107 ++++++++++
 tb/tb_fetch_sequencer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// fetch_sequencer -- single-issue instruction fetch/decode/execute sequencer.
//
// Steps a program counter through instruction memory with a four-state FSM:
// IDLE -> FETCH -> DECODE -> EXECUTE -> FETCH ...
// One unstalled instruction takes three cycles. The PC advances (or is
// redirected by a taken branch) only on the edge that leaves EXECUTE
// unstalled. A halt request sampled at that same edge sends the FSM back to
// IDLE after the branch/increment has been applied.
//
// Ports:
//   clk            clock, rising-edge active
//   rst            asynchronous active-high reset
//   start          leave IDLE and begin fetching at the current PC
//   halt_req       return to IDLE when the current instruction retires
//   stall          hold EXECUTE while the datapath is busy
//   branch_taken   redirect the PC to branch_target at EXECUTE exit
//   branch_target  redirect address
//   instruction    instruction-memory read data for pc_sel
//   pc_sel         current PC, drives the instruction-memory select
//   ir             instruction register
//   ir_valid       ir holds a live instruction (DECODE or EXECUTE)
//   exec_en        datapath execute strobe (EXECUTE)
//   state          FSM state: IDLE=00 FETCH=01 DECODE=10 EXECUTE=11
//   halted         sequencer is parked in IDLE
module fetch_sequencer #(
    parameter int              PC_W     = 4,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              DATA_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              halt_req,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [PC_W-1:0]   branch_target,
    input  logic [DATA_W-1:0] instruction,
    output logic [PC_W-1:0]   pc_sel,
    output logic [DATA_W-1:0] ir,
    output logic              ir_valid,
    output logic              exec_en,
    output logic [1:0]        state,
    output logic              halted
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        FETCH   = 2'b01,
        DECODE  = 2'b10,
        EXECUTE = 2'b11
    } state_t;

    state_t            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [DATA_W-1:0] ir_q;
    logic              halted_q;
    logic              retire;

    // The in-flight instruction retires on the unstalled edge out of EXECUTE;
    // this is the only point where branch and halt inputs matter.
    assign retire = (state_q == EXECUTE) && !stall;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = FETCH;
            FETCH:   state_d = DECODE;
            DECODE:  state_d = EXECUTE;
            EXECUTE: if (!stall) state_d = halt_req ? IDLE : FETCH;
            default: state_d = IDLE;
        endcase
    end

    // Increment wraps naturally at 2^PC_W.
    always_comb begin
        pc_d = pc_q;
        if (retire) begin
            pc_d = branch_taken ? branch_target : pc_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            ir_q     <= '0;
            halted_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            // Memory data for pc_sel is captured on the edge leaving FETCH.
            if (state_q == FETCH) begin
                ir_q <= instruction;
            end
            // Set on any entry into IDLE, cleared on the IDLE->FETCH edge.
            halted_q <= (state_d == IDLE);
        end
    end

    assign pc_sel   = pc_q;
    assign ir       = ir_q;
    assign state    = state_q;
    assign halted   = halted_q;
    assign exec_en  = (state_q == EXECUTE);
    assign ir_valid = (state_q == DECODE) || (state_q == EXECUTE);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Testbench for fetch_sequencer: table-driven vectors through a scoreboard
// queue, followed by hand-written wrap, stall, branch and async-reset runs.
module tb_fetch_sequencer;

    localparam logic [1:0] S_IDLE = 2'b00, S_FETCH = 2'b01,
                           S_DECODE = 2'b10, S_EXEC = 2'b11;

    logic       clk = 1'b0;
    logic       rst, start, halt_req, stall, branch_taken;
    logic [3:0] branch_target;
    logic [7:0] instruction;
    logic [3:0] pc_sel;
    logic [7:0] ir;
    logic       ir_valid, exec_en, halted;
    logic [1:0] state;

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic [1:0] st;
        logic [3:0] pc;
        logic [7:0] ir;
        logic       halted;
    } exp_t;

    typedef struct {
        logic       start, halt, stall, br;
        logic [3:0] tgt;
        exp_t       e;
    } vec_t;

    exp_t sbq[$];
    vec_t vt[20];
    logic [7:0] last;
    bit saw4 = 1'b0;

    fetch_sequencer #(.PC_W(4), .RESET_PC(4'h0), .DATA_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .halt_req(halt_req),
        .stall(stall), .branch_taken(branch_taken),
        .branch_target(branch_target), .instruction(instruction),
        .pc_sel(pc_sel), .ir(ir), .ir_valid(ir_valid), .exec_en(exec_en),
        .state(state), .halted(halted)
    );

    // Instruction memory: word k holds 8'h80 + k.
    assign instruction = 8'h80 + {4'h0, pc_sel};

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst && state == S_FETCH && pc_sel == 4'h4) saw4 <= 1'b1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    function automatic exp_t mk(logic [1:0] st, logic [3:0] pc, logic [7:0] irv, logic h);
        exp_t e;
        e.st = st; e.pc = pc; e.ir = irv; e.halted = h;
        return e;
    endfunction

    function automatic vec_t mv(logic s, logic h, logic sl, logic b, logic [3:0] t, exp_t e);
        vec_t v;
        v.start = s; v.halt = h; v.stall = sl; v.br = b; v.tgt = t; v.e = e;
        return v;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        total++;
        if (act !== req)
            $display("FAIL %s: got %0h required %0h", name, act, req);
        else
            passed++;
    endtask

    task automatic compare_all(input string tag, input exp_t e);
        check({tag, ".state"},    {6'b0, state},    {6'b0, e.st});
        check({tag, ".pc_sel"},   {4'b0, pc_sel},   {4'b0, e.pc});
        check({tag, ".ir"},       ir,               e.ir);
        check({tag, ".ir_valid"}, {7'b0, ir_valid}, {7'b0, (e.st == S_DECODE || e.st == S_EXEC)});
        check({tag, ".exec_en"},  {7'b0, exec_en},  {7'b0, (e.st == S_EXEC)});
        check({tag, ".halted"},   {7'b0, halted},   {7'b0, e.halted});
    endtask

    // Drive one cycle of inputs, queue the expected post-edge outputs, then
    // pop and compare once the DUT has clocked.
    task automatic step(input string tag, input logic s, input logic h, input logic sl,
                        input logic b, input logic [3:0] t, input exp_t e);
        exp_t got;
        @(negedge clk);
        start = s; halt_req = h; stall = sl; branch_taken = b; branch_target = t;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        got = sbq.pop_front();
        compare_all(tag, got);
    endtask

    // From FETCH at p: DECODE, EXECUTE, then FETCH at p+1.
    task automatic run_instr(input logic [3:0] p);
        logic [3:0] n;
        n = p + 4'h1;
        step("run_dec", 0, 0, 0, 0, 4'h0, mk(S_DECODE, p, 8'h80 + {4'h0, p}, 0));
        last = 8'h80 + {4'h0, p};
        step("run_exe", 0, 0, 0, 0, 4'h0, mk(S_EXEC, p, last, 0));
        step("run_fet", 0, 0, 0, 0, 4'h0, mk(S_FETCH, n, last, 0));
    endtask

    initial begin
        logic [3:0] p;
        int cnt;

        vt[0]  = mv(0, 0, 0, 0, 4'h0, mk(S_IDLE,   4'h0, 8'h00, 1));
        vt[1]  = mv(1, 0, 0, 0, 4'h0, mk(S_FETCH,  4'h0, 8'h00, 0));
        vt[2]  = mv(0, 1, 0, 0, 4'h0, mk(S_DECODE, 4'h0, 8'h80, 0));
        vt[3]  = mv(0, 0, 0, 0, 4'h0, mk(S_EXEC,   4'h0, 8'h80, 0));
        vt[4]  = mv(0, 0, 0, 0, 4'h0, mk(S_FETCH,  4'h1, 8'h80, 0));
        vt[5]  = mv(1, 0, 0, 0, 4'h0, mk(S_DECODE, 4'h1, 8'h81, 0));
        vt[6]  = mv(0, 1, 0, 1, 4'hF, mk(S_EXEC,   4'h1, 8'h81, 0));
        vt[7]  = mv(0, 1, 1, 1, 4'h9, mk(S_EXEC,   4'h1, 8'h81, 0));
        vt[8]  = mv(0, 0, 0, 0, 4'h0, mk(S_FETCH,  4'h2, 8'h81, 0));
        vt[9]  = mv(0, 0, 0, 0, 4'h0, mk(S_DECODE, 4'h2, 8'h82, 0));
        vt[10] = mv(0, 0, 0, 0, 4'h0, mk(S_EXEC,   4'h2, 8'h82, 0));
        vt[11] = mv(0, 0, 0, 1, 4'h7, mk(S_FETCH,  4'h7, 8'h82, 0));
        vt[12] = mv(0, 0, 0, 0, 4'h0, mk(S_DECODE, 4'h7, 8'h87, 0));
        vt[13] = mv(0, 0, 0, 0, 4'h0, mk(S_EXEC,   4'h7, 8'h87, 0));
        vt[14] = mv(0, 1, 0, 1, 4'hA, mk(S_IDLE,   4'hA, 8'h87, 1));
        vt[15] = mv(0, 1, 0, 1, 4'h3, mk(S_IDLE,   4'hA, 8'h87, 1));
        vt[16] = mv(1, 0, 0, 0, 4'h0, mk(S_FETCH,  4'hA, 8'h87, 0));
        vt[17] = mv(0, 0, 0, 0, 4'h0, mk(S_DECODE, 4'hA, 8'h8A, 0));
        vt[18] = mv(0, 0, 0, 0, 4'h0, mk(S_EXEC,   4'hA, 8'h8A, 0));
        vt[19] = mv(0, 1, 0, 0, 4'h0, mk(S_IDLE,   4'hB, 8'h8A, 1));

        rst = 1'b1; start = 0; halt_req = 0; stall = 0; branch_taken = 0; branch_target = 4'h0;
        #2;
        compare_all("reset_async", mk(S_IDLE, 4'h0, 8'h00, 1));
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 20; i++) begin
            step($sformatf("vec%0d", i), vt[i].start, vt[i].halt, vt[i].stall,
                 vt[i].br, vt[i].tgt, vt[i].e);
        end

        // Resume at B and run through F; the increment must wrap to 0.
        last = 8'h8A;
        step("wrap_start", 1, 0, 0, 0, 4'h0, mk(S_FETCH, 4'hB, last, 0));
        p = 4'hB;
        for (int i = 0; i < 5; i++) begin
            run_instr(p);
            p = p + 4'h1;
        end
        check("wrap_pc", {4'b0, pc_sel}, 8'h00);
        check("wrap_state", {6'b0, state}, {6'b0, S_FETCH});
        run_instr(4'h0);
        run_instr(4'h1);

        // Stall four cycles in EXECUTE at PC 2; branch inputs must be ignored.
        step("stall_dec", 0, 0, 0, 0, 4'h0, mk(S_DECODE, 4'h2, 8'h82, 0));
        step("stall_exe", 0, 0, 0, 0, 4'h0, mk(S_EXEC, 4'h2, 8'h82, 0));
        cnt = exec_en ? 1 : 0;
        for (int i = 0; i < 4; i++) begin
            step("stall_hold", 0, 1, 1, 1, 4'h9, mk(S_EXEC, 4'h2, 8'h82, 0));
            if (exec_en) cnt++;
        end
        check("stall_exec_cycles", 8'(cnt), 8'd5);
        step("stall_release", 0, 0, 0, 0, 4'h0, mk(S_FETCH, 4'h3, 8'h82, 0));

        // Branch from PC 3 to 7: PC 4 must never be fetched.
        step("br_dec", 0, 0, 0, 0, 4'h0, mk(S_DECODE, 4'h3, 8'h83, 0));
        step("br_exe", 0, 0, 0, 0, 4'h0, mk(S_EXEC, 4'h3, 8'h83, 0));
        step("br_take", 0, 0, 0, 1, 4'h7, mk(S_FETCH, 4'h7, 8'h83, 0));
        step("br_dec7", 0, 0, 0, 0, 4'h0, mk(S_DECODE, 4'h7, 8'h87, 0));
        check("br_no_pc4", {7'b0, saw4}, 8'h00);

        // Branch to 5, then reset asynchronously in the middle of EXECUTE.
        step("br_exe7", 0, 0, 0, 0, 4'h0, mk(S_EXEC, 4'h7, 8'h87, 0));
        step("br_to5", 0, 0, 0, 1, 4'h5, mk(S_FETCH, 4'h5, 8'h87, 0));
        step("dec5", 0, 0, 0, 0, 4'h0, mk(S_DECODE, 4'h5, 8'h85, 0));
        step("exe5", 0, 0, 1, 0, 4'h0, mk(S_EXEC, 4'h5, 8'h85, 0));
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        compare_all("rst_mid_exec", mk(S_IDLE, 4'h0, 8'h00, 1));
        @(negedge clk);
        start = 0; halt_req = 0; stall = 0; branch_taken = 0;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step("post_rst_idle", 0, 1, 0, 1, 4'hC, mk(S_IDLE, 4'h0, 8'h00, 1));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
